// File: rtl/shift_pkg.sv
// Shared definitions for the iterative normalizer: fixed widths, FSM encoding
// and the normalized/degenerate predicates used by the RTL and its bench.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned: top bit set. Signed: top two bits differ (no redundant sign bit).
    function automatic logic is_norm(input logic [XLEN-1:0] value, input logic arith);
        logic res;
        if (arith) begin
            res = value[XLEN-1] ^ value[XLEN-2];
        end else begin
            res = value[XLEN-1];
        end
        return res;
    endfunction

    // Operands that no amount of left shifting can normalize.
    function automatic logic is_degenerate(input logic [XLEN-1:0] value, input logic arith);
        logic res;
        if (arith) begin
            res = (value == {XLEN{1'b0}}) || (value == {XLEN{1'b1}});
        end else begin
            res = (value == {XLEN{1'b0}});
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_norm.sv
// Iterative normalizer: shifts the operand left one bit per cycle until it is
// normalized (unsigned or signed) and reports the value and the shift count.
module shift_norm
    import shift_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [XLEN-1:0]    a_in,
    input  logic               arith_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    norm_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic               zero_o
);

    state_t               state_r;
    state_t               state_s;
    logic [XLEN-1:0]      value_r;
    logic [XLEN-1:0]      value_s;
    logic [XLEN-1:0]      shifted_s;
    logic [SHAMT_W-1:0]   count_r;
    logic [SHAMT_W-1:0]   count_s;
    logic [SHAMT_W-1:0]   count_inc_s;
    logic                 arith_r;
    logic                 arith_s;
    logic [XLEN-1:0]      norm_r;
    logic [XLEN-1:0]      norm_s;
    logic [SHAMT_W-1:0]   shamt_r;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 zero_r;
    logic                 zero_s;
    logic                 ready_r;
    logic                 valid_r;

    assign shifted_s   = {value_r[XLEN-2:0], 1'b0};
    assign count_inc_s = count_r + 5'd1;

    // Next-state, datapath and result-register update logic.
    always_comb begin
        state_s = state_r;
        value_s = value_r;
        count_s = count_r;
        arith_s = arith_r;
        norm_s  = norm_r;
        shamt_s = shamt_r;
        zero_s  = zero_r;
        case (state_r)
            IDLE: begin
                if (valid_i) begin
                    value_s = a_in;
                    arith_s = arith_i;
                    count_s = 5'd0;
                    if (is_degenerate(a_in, arith_i)) begin
                        zero_s  = 1'b1;
                        norm_s  = a_in;
                        shamt_s = 5'd0;
                        state_s = DONE;
                    end else if (is_norm(a_in, arith_i)) begin
                        zero_s  = 1'b0;
                        norm_s  = a_in;
                        shamt_s = 5'd0;
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                value_s = shifted_s;
                count_s = count_inc_s;
                // Non-degenerate operands always reach a normalized form
                // within 31 shifts, so the counter cannot wrap.
                if (is_norm(shifted_s, arith_r)) begin
                    norm_s  = shifted_s;
                    shamt_s = count_inc_s;
                    zero_s  = 1'b0;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and working datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            value_r <= 32'd0;
            count_r <= 5'd0;
            arith_r <= 1'b0;
        end else begin
            state_r <= state_s;
            value_r <= value_s;
            count_r <= count_s;
            arith_r <= arith_s;
        end
    end

    // Registered result and handshake outputs, decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            norm_r  <= 32'd0;
            shamt_r <= 5'd0;
            zero_r  <= 1'b0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            norm_r  <= norm_s;
            shamt_r <= shamt_s;
            zero_r  <= zero_s;
            ready_r <= (state_s == IDLE);
            valid_r <= (state_s == DONE);
        end
    end

    assign ready_o = ready_r;
    assign valid_o = valid_r;
    assign norm_o  = norm_r;
    assign shamt_o = shamt_r;
    assign zero_o  = zero_r;

endmodule

// File: tb/tb_shift_norm.sv
// Directed and randomized self-checking bench for shift_norm.
module tb_shift_norm;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_in;
    logic        arith_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] norm_o;
    logic [4:0]  shamt_o;
    logic        zero_o;

    int n_checks;
    int n_errors;

    shift_norm dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_in    (a_in),
        .arith_i (arith_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .norm_o  (norm_o),
        .shamt_o (shamt_o),
        .zero_o  (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: count leading zeros / redundant sign bits bit by bit.
    task automatic model(input logic [31:0] a, input logic ar,
                         output logic [31:0] en, output logic [4:0] ek, output logic ez);
        int k;
        ez = ar ? ((a == 32'h0) || (a == 32'hFFFF_FFFF)) : (a == 32'h0);
        k = 0;
        if (!ez) begin
            if (ar) begin
                for (int i = 30; i >= 0 && a[i] == a[31]; i--) k++;
            end else begin
                for (int i = 31; i >= 0 && a[i] == 1'b0; i--) k++;
            end
        end
        ek = 5'(k);
        en = a << k;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic ar,
                         input logic [31:0] en, input logic [4:0] ek, input logic ez,
                         output logic [31:0] on, output logic [4:0] ok, output logic oz);
        int lat;
        @(negedge clk);
        check_val({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        a_in    = a;
        arith_i = ar;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a_in    = $urandom;
        arith_i = ~ar;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd1 + {27'd0, ek});
        check_val({tag, "_norm"}, norm_o, en);
        check_val({tag, "_shamt"}, {27'd0, shamt_o}, {27'd0, ek});
        check_val({tag, "_zero"}, {31'd0, zero_o}, {31'd0, ez});
        on = norm_o;
        ok = shamt_o;
        oz = zero_o;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check_val({tag, "_vld_drop"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] on, en, a, inv;
        logic [4:0]  ok, ek;
        logic        oz, ez, ar;
        int          lat;
        n_checks = 0;
        n_errors = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_in    = 32'd0;
        arith_i = 1'b0;
        #12;
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_norm", norm_o, 32'd0);
        check_val("rst_shamt", {27'd0, shamt_o}, 32'd0);
        check_val("rst_zero", {31'd0, zero_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_ready", {31'd0, ready_o}, 32'd1);

        do_op("u_one",  32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, on, ok, oz);
        do_op("u_msb",  32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0, on, ok, oz);
        do_op("s_fff0", 32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 5'd27, 1'b0, on, ok, oz);
        do_op("s_ff",   32'h0000_00FF, 1'b1, 32'h7F80_0000, 5'd23, 1'b0, on, ok, oz);
        do_op("u_zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, on, ok, oz);
        do_op("s_ones", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b1, on, ok, oz);
        do_op("s_one",  32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0, on, ok, oz);
        do_op("s_fffe", 32'hFFFF_FFFE, 1'b1, 32'h8000_0000, 5'd30, 1'b0, on, ok, oz);
        do_op("u_ones", 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0, on, ok, oz);
        do_op("s_zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, on, ok, oz);

        // Backpressure: result held while new requests knock at the door.
        @(negedge clk);
        valid_i = 1'b1;
        a_in    = 32'h00F0_0000;
        arith_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("bp_lat", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            a_in    = $urandom;
            arith_i = i[0];
            @(posedge clk);
            #1;
            check_val("bp_valid", {31'd0, valid_o}, 32'd1);
            check_val("bp_ready", {31'd0, ready_o}, 32'd0);
            check_val("bp_norm", norm_o, 32'hF000_0000);
            check_val("bp_shamt", {27'd0, shamt_o}, 32'd8);
            check_val("bp_zero", {31'd0, zero_o}, 32'd0);
        end
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b1;
        a_in    = 32'h8000_0001;
        arith_i = 1'b0;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        check_val("bp_hs_valid", {31'd0, valid_o}, 32'd0);
        check_val("bp_hs_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        check_val("bp_not_taken", {31'd0, valid_o}, 32'd0);
        do_op("bp_next", 32'h8000_0001, 1'b0, 32'h8000_0001, 5'd0, 1'b0, on, ok, oz);

        // Reset in the middle of a long run.
        @(negedge clk);
        valid_i = 1'b1;
        a_in    = 32'h0000_0001;
        arith_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", {31'd0, valid_o}, 32'd0);
        check_val("mrst_norm", norm_o, 32'd0);
        check_val("mrst_shamt", {27'd0, shamt_o}, 32'd0);
        check_val("mrst_zero", {31'd0, zero_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("mrst_no_valid", {31'd0, valid_o}, 32'd0);
        do_op("mrst_next", 32'h0000_0100, 1'b0, 32'h8000_0000, 5'd23, 1'b0, on, ok, oz);

        // Random operands in both modes, biased toward long shift counts.
        for (int i = 0; i < 2000; i++) begin
            a  = $urandom >> $urandom_range(0, 31);
            ar = i[0];
            if (ar && $urandom_range(0, 1) == 1) a = ~a;
            model(a, ar, en, ek, ez);
            do_op("rnd", a, ar, en, ek, ez, on, ok, oz);
            if (ar) begin
                inv = $unsigned($signed(on) >>> ok);
            end else begin
                inv = on >> ok;
            end
            check_val("rnd_inverse", inv, a);
            check_val("rnd_normed", {31'd0, is_norm(on, ar) | oz}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
